// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: format encodings,
// reset defaults, the receive state type and the FIFO word layout.
package uart_pkg;

    localparam logic [1:0] DN_6 = 2'b00;
    localparam logic [1:0] DN_7 = 2'b01;
    localparam logic [1:0] DN_8 = 2'b10;

    localparam logic [1:0] SN_1   = 2'b00;
    localparam logic [1:0] SN_1P5 = 2'b01;
    localparam logic [1:0] SN_2   = 2'b10;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam int unsigned RST_DIV = 650;
    localparam logic [1:0] RST_DATA_NUM = DN_8;
    localparam logic [1:0] RST_STOP_NUM = SN_1;
    localparam logic [1:0] RST_PAR      = PAR_NONE;

    localparam int FIFO_W  = 10;
    localparam int PAR_BIT = 9;
    localparam int FRM_BIT = 8;

    typedef enum logic {
        ST_IDLE,
        ST_FRAME
    } rx_state_t;

    typedef struct packed {
        logic [1:0] data_num;
        logic [1:0] stop_num;
        logic [1:0] par;
    } frame_fmt_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; the head word is visible while not empty.
// Full/empty come from the wrap bit carried above the address bits.
module sync_fifo #(
    parameter int W  = 10,
    parameter int AW = 4
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    input  logic         i_wr,
    input  logic         i_rd,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data,
    output logic         o_empty,
    output logic         o_full
);

    logic [W-1:0] mem [2**AW];
    logic [AW:0]  wptr_q;
    logic [AW:0]  rptr_q;
    logic         do_rd;
    logic         do_wr;

    assign o_empty = (wptr_q == rptr_q);
    assign o_full  = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

    // A pop frees the slot a full-FIFO push is about to reuse.
    assign do_rd = i_rd && !o_empty;
    assign do_wr = i_wr && (!o_full || do_rd);

    assign o_data = mem[rptr_q[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (do_wr)
            mem[wptr_q[AW-1:0]] <= i_data;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_wr)
                wptr_q <= wptr_q + (AW+1)'(1);
            if (do_rd)
                rptr_q <= rptr_q + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver controller: baud tick, frame format with deferred apply,
// frame tracking, buffered words with error flags and error statistics.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int          W_DIV       = 11,
    parameter int unsigned DEFAULT_DIV = RST_DIV,
    parameter int          FIFO_AW     = 4
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_rx,
    input  logic             i_cfg_wr,
    input  logic [W_DIV-1:0] i_cfg_div,
    input  logic [1:0]       i_cfg_data_num,
    input  logic [1:0]       i_cfg_stop_num,
    input  logic [1:0]       i_cfg_par,
    output logic             o_baud_tick,
    output logic [1:0]       o_data_num,
    output logic [1:0]       o_stop_num,
    output logic [1:0]       o_par,
    input  logic             i_rx_done_tick,
    input  logic             i_par_err,
    input  logic             i_frm_err,
    input  logic [7:0]       i_rx_data,
    input  logic             i_rd,
    output logic [9:0]       o_rd_data,
    output logic             o_empty,
    output logic             o_full,
    output logic             o_cfg_pending,
    output logic             o_busy,
    output logic             o_overrun,
    input  logic             i_clr_stat,
    output logic [7:0]       o_par_cnt,
    output logic [7:0]       o_frm_cnt
);

    rx_state_t        state_q;
    rx_state_t        state_d;
    logic             start;
    logic             par_flag_q;
    logic             par_now;
    logic             apply;
    logic [W_DIV-1:0] div_q;
    logic [W_DIV-1:0] div_sh_q;
    logic [W_DIV-1:0] div_d;
    logic [W_DIV-1:0] cnt_q;
    logic [W_DIV-1:0] cnt_d;
    logic             tick_q;
    logic             pend_q;
    frame_fmt_t       fmt_q;
    frame_fmt_t       fmt_sh_q;
    frame_fmt_t       fmt_rst;
    logic [FIFO_W-1:0] push_word;
    logic             ovr_q;
    logic [7:0]       par_cnt_q;
    logic [7:0]       frm_cnt_q;

    assign fmt_rst = '{data_num: RST_DATA_NUM,
                       stop_num: RST_STOP_NUM,
                       par:      RST_PAR};

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!i_rx) begin
                    state_d = ST_FRAME;
                    start   = 1'b1;
                end
            end
            ST_FRAME: begin
                if (i_rx_done_tick)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign o_busy = (state_q == ST_FRAME);

    // Parity error arrives before the done tick; hold it for the push.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            par_flag_q <= 1'b0;
        else if (start)
            par_flag_q <= 1'b0;
        else if (i_par_err)
            par_flag_q <= 1'b1;
    end

    assign par_now = par_flag_q || i_par_err;

    assign apply = pend_q && !o_busy;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            div_q    <= W_DIV'(DEFAULT_DIV);
            div_sh_q <= W_DIV'(DEFAULT_DIV);
            fmt_q    <= fmt_rst;
            fmt_sh_q <= fmt_rst;
            pend_q   <= 1'b0;
        end else begin
            if (apply) begin
                div_q <= div_sh_q;
                fmt_q <= fmt_sh_q;
            end
            if (i_cfg_wr) begin
                div_sh_q <= i_cfg_div;
                fmt_sh_q <= '{data_num: i_cfg_data_num,
                              stop_num: i_cfg_stop_num,
                              par:      i_cfg_par};
                pend_q   <= 1'b1;
            end else if (apply) begin
                pend_q <= 1'b0;
            end
        end
    end

    // Tick is registered from the next count so it marks count == div.
    always_comb begin
        div_d = apply ? div_sh_q : div_q;
        if (apply || cnt_q == div_q)
            cnt_d = '0;
        else
            cnt_d = cnt_q + W_DIV'(1);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= (cnt_d == div_d);
        end
    end

    assign o_baud_tick   = tick_q;
    assign o_cfg_pending = pend_q;
    assign o_data_num    = fmt_q.data_num;
    assign o_stop_num    = fmt_q.stop_num;
    assign o_par         = fmt_q.par;

    always_comb begin
        push_word          = '0;
        push_word[7:0]     = i_rx_data;
        push_word[FRM_BIT] = i_frm_err;
        push_word[PAR_BIT] = par_now;
    end

    sync_fifo #(
        .W  (FIFO_W),
        .AW (FIFO_AW)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_wr      (i_rx_done_tick),
        .i_rd      (i_rd),
        .i_data    (push_word),
        .o_data    (o_rd_data),
        .o_empty   (o_empty),
        .o_full    (o_full)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            ovr_q     <= 1'b0;
            par_cnt_q <= '0;
            frm_cnt_q <= '0;
        end else if (i_clr_stat) begin
            ovr_q     <= 1'b0;
            par_cnt_q <= '0;
            frm_cnt_q <= '0;
        end else begin
            if (i_rx_done_tick && o_full && !i_rd)
                ovr_q <= 1'b1;
            if (i_rx_done_tick && par_now)
                par_cnt_q <= sat_inc(par_cnt_q);
            if (i_rx_done_tick && i_frm_err)
                frm_cnt_q <= sat_inc(frm_cnt_q);
        end
    end

    assign o_overrun = ovr_q;
    assign o_par_cnt = par_cnt_q;
    assign o_frm_cnt = frm_cnt_q;

endmodule
